// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: drives Vy to zero two micro-rotations per clock,
// returning the gain-scaled magnitude and the vector angle in whole degrees.
module cordic_vectoring_iter #(
   parameter int XY_W   = 19,
   parameter int Z_W    = 9,
   parameter int N_ITER = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [XY_W-1:0] Vx,
   input  logic signed [XY_W-1:0] Vy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [XY_W-1:0] mag,
   output logic signed [Z_W-1:0]  angle
);

   localparam int N_PAIR = N_ITER / 2;
   localparam int K_W    = (N_PAIR > 1) ? $clog2(N_PAIR) : 1;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t                 state, state_nxt;
   logic [K_W-1:0]         k;
   logic signed [XY_W-1:0] x, y, x0, y0, x1, y1, x2, y2;
   logic signed [Z_W-1:0]  z, z0, z1, z2;
   logic [3:0]             idx0, idx1;
   logic                   last_pair;

   function automatic logic signed [Z_W-1:0] atan_deg(input logic [3:0] i);
      case (i)
         4'd0:    atan_deg = Z_W'(45);
         4'd1:    atan_deg = Z_W'(27);
         4'd2:    atan_deg = Z_W'(14);
         4'd3:    atan_deg = Z_W'(7);
         4'd4:    atan_deg = Z_W'(4);
         4'd5:    atan_deg = Z_W'(2);
         4'd6:    atan_deg = Z_W'(1);
         default: atan_deg = '0;
      endcase
   endfunction

   assign in_ready  = (state == IDLE);
   assign last_pair = (k == K_W'(N_PAIR - 1));

   // Quadrant pre-rotation folds the left half-plane into |angle| <= 90 before iterating.
   always_comb begin
      x0 = Vx;
      y0 = Vy;
      z0 = '0;
      if (Vx[XY_W-1]) begin
         if (!Vy[XY_W-1]) begin
            x0 = Vy;
            y0 = -Vx;
            z0 = Z_W'(90);
         end else begin
            x0 = -Vy;
            y0 = Vx;
            z0 = Z_W'(-90);
         end
      end
   end

   // Two chained micro-rotations: i = 2k feeds i = 2k+1 within the same cycle.
   always_comb begin
      idx0 = 4'({k, 1'b0});
      idx1 = idx0 | 4'd1;
      if (!y[XY_W-1]) begin
         x1 = x + (y >>> idx0);
         y1 = y - (x >>> idx0);
         z1 = z + atan_deg(idx0);
      end else begin
         x1 = x - (y >>> idx0);
         y1 = y + (x >>> idx0);
         z1 = z - atan_deg(idx0);
      end
      if (!y1[XY_W-1]) begin
         x2 = x1 + (y1 >>> idx1);
         y2 = y1 - (x1 >>> idx1);
         z2 = z1 + atan_deg(idx1);
      end else begin
         x2 = x1 - (y1 >>> idx1);
         y2 = y1 + (x1 >>> idx1);
         z2 = z1 - atan_deg(idx1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = ITER;
         ITER:    if (last_pair) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x         <= '0;
         y         <= '0;
         z         <= '0;
         k         <= '0;
         mag       <= '0;
         angle     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x <= x0;
                  y <= y0;
                  z <= z0;
                  k <= '0;
               end
            end
            ITER: begin
               x <= x2;
               y <= y2;
               z <= z2;
               k <= k + K_W'(1);
               if (last_pair) begin
                  mag       <= x2;
                  angle     <= z2;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
